seg7_scan_mux: RTL and testbench

- Upstream feeder for the 74LV595 serial display driver.
- Time-multiplexes four independent 8-digit hex displays.
- Each cycle it presents one 16-bit word per chain: {digit_select[7:0], segments[7:0]}, held stable long enough for the driver's 32-clk shift/latch frame to capture it.
- Includes per-digit blanking, inter-digit ghost blanking and tear-free input snapshotting.

---
 rtl/seg7_scan_mux.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//
// Purpose:
//   Time-multiplexes four independent 8-digit hex displays. It feeds a
//   74LV595-style serial display driver. Every clk cycle each chain gets one
//   16-bit word {dig[7:0], seg[7:0]}. That word stays stable for at least
//   BLANK_CYC cycles, so the driver's 32-cycle shift/latch frame always
//   captures a consistent value.
//
//   A scan visits digits 0..7, one slot of SCAN_DIV cycles per digit. The
//   first BLANK_CYC cycles of each slot drive everything inactive, which
//   suppresses ghosting between digits. All inputs are snapshotted once per
//   scan, at the start of digit 0. A scan therefore never mixes old and new
//   values.
//
// Parameters:
//   SCAN_DIV        clk cycles per digit slot (power of 2, >= 64)
//   BLANK_CYC       blank cycles at the start of each slot (>= 32, < SCAN_DIV)
//   SEG_ACTIVE_LOW  1 = a lit segment is driven as 0
//   DIG_ACTIVE_LOW  1 = the selected digit is driven as 0
//
// Optional feature (macro SEG7_SCAN_DIM_EN):
//   Adds the brightness[3:0] input, which is snapshotted with the values.
//   Each slot is split into 16 sub-slots. A digit is lit only while the
//   sub-slot number is <= brightness. Without the macro, the design behaves
//   as if brightness were 15.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   brightness      [3:0] dimming level (only with SEG7_SCAN_DIM_EN)
//   value_0..3      [31:0] hex digits, digit i = value_k[4i+3:4i]
//   dp_0..3         [7:0] decimal point per digit
//   blank_0..3      [7:0] 1 = digit shows nothing
//   data_0..3       [15:0] {dig, seg} word to the driver chains
//   digit_idx       [2:0] digit currently being scanned
//
// Segment order: seg[7:0] = {dp,g,f,e,d,c,b,a}.

module seg7_scan_mux #(
  parameter int SCAN_DIV       = 4096,
  parameter int BLANK_CYC      = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]  brightness,
`endif
  input  logic [31:0] value_0,
  input  logic [31:0] value_1,
  input  logic [31:0] value_2,
  input  logic [31:0] value_3,
  input  logic [7:0]  dp_0,
  input  logic [7:0]  dp_1,
  input  logic [7:0]  dp_2,
  input  logic [7:0]  dp_3,
  input  logic [7:0]  blank_0,
  input  logic [7:0]  blank_1,
  input  logic [7:0]  blank_2,
  input  logic [7:0]  blank_3,
  output logic [15:0] data_0,
  output logic [15:0] data_1,
  output logic [15:0] data_2,
  output logic [15:0] data_3,
  output logic [2:0]  digit_idx
);

  localparam int              DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [7:0]      SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0]      DIG_INV   = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [15:0]     INACTIVE  = {DIG_INV, SEG_INV};

  logic [DIV_W-1:0]  div_cnt;
  logic [3:0][31:0]  in_value;
  logic [3:0][7:0]   in_dp;
  logic [3:0][7:0]   in_blank;
  logic [3:0][31:0]  snap_value;
  logic [3:0][7:0]   snap_dp;
  logic [3:0][7:0]   snap_blank;
  logic [3:0][15:0]  data_q;
  logic [3:0][15:0]  data_next;
  logic              lit;
  logic [7:0]        dig;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]        snap_brightness;
`endif

  assign in_value = {value_3, value_2, value_1, value_0};
  assign in_dp    = {dp_3, dp_2, dp_1, dp_0};
  assign in_blank = {blank_3, blank_2, blank_1, blank_0};

  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];

  // Active-high 7-segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    hex_to_seg = 7'h00;
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Active-high segment byte for one chain. A blanked digit keeps its dig
  // line active, but its segments go dark.
  function automatic logic [7:0] seg_byte(input logic [31:0] value,
                                          input logic [7:0]  dp,
                                          input logic [7:0]  blank,
                                          input logic [2:0]  idx);
    seg_byte = {dp[idx], hex_to_seg(value[{idx, 2'b00} +: 4])};
    if (blank[idx]) begin
      seg_byte = 8'h00;
    end
  endfunction

  // Slot counter, digit counter and the once-per-scan input snapshot.
  // The snapshot fires whenever the counters sit at digit 0, count 0. That
  // includes the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      digit_idx  <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
`ifdef SEG7_SCAN_DIM_EN
      snap_brightness <= '0;
`endif
      data_q     <= {4{INACTIVE}};
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (div_cnt == DIV_LAST) begin
        digit_idx <= digit_idx + 3'd1;
      end
      if (div_cnt == '0 && digit_idx == '0) begin
        snap_value <= in_value;
        snap_dp    <= in_dp;
        snap_blank <= in_blank;
`ifdef SEG7_SCAN_DIM_EN
        snap_brightness <= brightness;
`endif
      end
      data_q <= data_next;
    end
  end

  // Next output words are built from the current counters and snapshot.
  // The registered outputs therefore trail the counters by one cycle.
  always_comb begin
    lit = (div_cnt >= BLANK_END);
`ifdef SEG7_SCAN_DIM_EN
    lit = lit && (div_cnt[DIV_W-1 -: 4] <= snap_brightness);
`endif
    dig = lit ? (8'd1 << digit_idx) : 8'h00;
    data_next = '0;
    for (int k = 0; k < 4; k++) begin
      data_next[k] = {dig ^ DIG_INV,
                      (lit ? seg_byte(snap_value[k], snap_dp[k], snap_blank[k], digit_idx)
                           : 8'h00) ^ SEG_INV};
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux
//
// Purpose:
//   Directed testbench for seg7_scan_mux. One instance uses SCAN_DIV=64 and
//   BLANK_CYC=32 with active-high polarity. A second instance uses the same
//   timing with both polarities active-low. When SEG7_SCAN_DIM_EN is defined,
//   a third instance (SCAN_DIV=256) exercises the brightness control.
//
//   Counter "cyc" is the number of rising edges since the instance under
//   test left reset. The output sampled after edge n reflects counter
//   state n-1: slot (n-1)/64 and count (n-1)%64.

module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_b = 1'b1;
  logic [31:0] value_0 = '0, value_1 = '0, value_2 = '0, value_3 = '0;
  logic [7:0]  dp_0 = '0, dp_1 = '0, dp_2 = '0, dp_3 = '0;
  logic [7:0]  blank_0 = '0, blank_1 = '0, blank_2 = '0, blank_3 = '0;
  logic [31:0] value_b0 = '0;
  logic [31:0] zero32 = '0;
  logic [7:0]  zero8 = '0;
  logic [15:0] data_0, data_1, data_2, data_3;
  logic [15:0] data_b0, data_b1, data_b2, data_b3;
  logic [2:0]  digit_idx, digit_idx_b;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

`ifdef SEG7_SCAN_DIM_EN
  logic        reset_c = 1'b1;
  logic [3:0]  brightness_c = 4'd7;
  logic [3:0]  full_bright = 4'hF;
  logic [15:0] data_c0, data_c1, data_c2, data_c3;
  logic [2:0]  digit_idx_c;
`endif

  always #5 clk = ~clk;

  seg7_scan_mux #(.SCAN_DIV(64), .BLANK_CYC(32), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .reset(reset),
`ifdef SEG7_SCAN_DIM_EN
    .brightness(full_bright),
`endif
    .value_0(value_0), .value_1(value_1), .value_2(value_2), .value_3(value_3),
    .dp_0(dp_0), .dp_1(dp_1), .dp_2(dp_2), .dp_3(dp_3),
    .blank_0(blank_0), .blank_1(blank_1), .blank_2(blank_2), .blank_3(blank_3),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .digit_idx(digit_idx)
  );

  seg7_scan_mux #(.SCAN_DIV(64), .BLANK_CYC(32), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_low (
    .clk(clk), .reset(reset_b),
`ifdef SEG7_SCAN_DIM_EN
    .brightness(full_bright),
`endif
    .value_0(value_b0), .value_1(zero32), .value_2(zero32), .value_3(zero32),
    .dp_0(zero8), .dp_1(zero8), .dp_2(zero8), .dp_3(zero8),
    .blank_0(zero8), .blank_1(zero8), .blank_2(zero8), .blank_3(zero8),
    .data_0(data_b0), .data_1(data_b1), .data_2(data_b2), .data_3(data_b3),
    .digit_idx(digit_idx_b)
  );

`ifdef SEG7_SCAN_DIM_EN
  seg7_scan_mux #(.SCAN_DIV(256), .BLANK_CYC(32), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut_dim (
    .clk(clk), .reset(reset_c),
    .brightness(brightness_c),
    .value_0(zero32), .value_1(zero32), .value_2(zero32), .value_3(zero32),
    .dp_0(zero8), .dp_1(zero8), .dp_2(zero8), .dp_3(zero8),
    .blank_0(zero8), .blank_1(zero8), .blank_2(zero8), .blank_3(zero8),
    .data_0(data_c0), .data_1(data_c1), .data_2(data_c2), .data_3(data_c3),
    .digit_idx(digit_idx_c)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    value_0 = 32'h7654_3210;
    value_1 = 32'hFEDC_BA98;
    value_2 = 32'h0000_0030;
    dp_2    = 8'h02;
    blank_2 = 8'h04;
    repeat (3) tick();
    checks++; if (data_0 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_0 got=%h exp=%h", data_0, 16'h0000); end
    checks++; if (data_1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_1 got=%h exp=%h", data_1, 16'h0000); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_2 got=%h exp=%h", data_2, 16'h0000); end
    checks++; if (data_3 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_3 got=%h exp=%h", data_3, 16'h0000); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_digit_idx got=%0d exp=%0d", digit_idx, 0); end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_slot_timing();
    run_to(32);
    checks++; if (data_0 !== 16'h0000) begin errors++; $display("[TB] FAIL blank_before_lit got=%h exp=%h", data_0, 16'h0000); end
    run_to(33);
    checks++; if (data_0 !== 16'h013F) begin errors++; $display("[TB] FAIL first_lit got=%h exp=%h", data_0, 16'h013F); end
    checks++; if (data_3 !== 16'h013F) begin errors++; $display("[TB] FAIL lockstep_chain3 got=%h exp=%h", data_3, 16'h013F); end
    run_to(64);
    checks++; if (data_0 !== 16'h013F) begin errors++; $display("[TB] FAIL last_lit_slot0 got=%h exp=%h", data_0, 16'h013F); end
    run_to(65);
    checks++; if (data_0 !== 16'h0000) begin errors++; $display("[TB] FAIL ghost_blank_start got=%h exp=%h", data_0, 16'h0000); end
    run_to(96);
    checks++; if (data_0 !== 16'h0000) begin errors++; $display("[TB] FAIL ghost_blank_end got=%h exp=%h", data_0, 16'h0000); end
    run_to(97);
    checks++; if (data_0 !== 16'h0206) begin errors++; $display("[TB] FAIL digit1_lit got=%h exp=%h", data_0, 16'h0206); end
    checks++; if (digit_idx !== 3'd1) begin errors++; $display("[TB] FAIL digit_idx_slot1 got=%0d exp=%0d", digit_idx, 1); end
  endtask

  task automatic test_blank_dp();
    run_to(120);
    checks++; if (data_2 !== 16'h02CF) begin errors++; $display("[TB] FAIL dp_digit1 got=%h exp=%h", data_2, 16'h02CF); end
    run_to(160);
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("[TB] FAIL blanked_digit_ghost got=%h exp=%h", data_2, 16'h0000); end
    run_to(161);
    checks++; if (data_2 !== 16'h0400) begin errors++; $display("[TB] FAIL blanked_digit2 got=%h exp=%h", data_2, 16'h0400); end
  endtask

  task automatic test_full_scan();
    run_to(289);
    checks++; if (data_1 !== 16'h1039) begin errors++; $display("[TB] FAIL scan_digit4 got=%h exp=%h", data_1, 16'h1039); end
    run_to(481);
    checks++; if (data_1 !== 16'h8071) begin errors++; $display("[TB] FAIL scan_digit7 got=%h exp=%h", data_1, 16'h8071); end
    run_to(511);
    checks++; if (digit_idx !== 3'd7) begin errors++; $display("[TB] FAIL digit_idx_7 got=%0d exp=%0d", digit_idx, 7); end
    run_to(512);
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("[TB] FAIL digit_idx_wrap got=%0d exp=%0d", digit_idx, 0); end
    run_to(545);
    checks++; if (data_1 !== 16'h017F) begin errors++; $display("[TB] FAIL scan2_digit0 got=%h exp=%h", data_1, 16'h017F); end
  endtask

  task automatic test_snapshot();
    run_to(712);
    value_0 = 32'hE000_000A;
    run_to(744);
    checks++; if (data_0 !== 16'h084F) begin errors++; $display("[TB] FAIL snap_old_digit3 got=%h exp=%h", data_0, 16'h084F); end
    run_to(993);
    checks++; if (data_0 !== 16'h8007) begin errors++; $display("[TB] FAIL snap_old_digit7 got=%h exp=%h", data_0, 16'h8007); end
    run_to(1057);
    checks++; if (data_0 !== 16'h0177) begin errors++; $display("[TB] FAIL snap_new_digit0 got=%h exp=%h", data_0, 16'h0177); end
    run_to(1505);
    checks++; if (data_0 !== 16'h8079) begin errors++; $display("[TB] FAIL snap_new_digit7 got=%h exp=%h", data_0, 16'h8079); end
  endtask

  task automatic test_polarity();
    value_b0 = 32'h0000_0008;
    tick();
    checks++; if (data_b0 !== 16'hFFFF) begin errors++; $display("[TB] FAIL low_reset got=%h exp=%h", data_b0, 16'hFFFF); end
    reset_b = 1'b0;
    cyc = 0;
    run_to(32);
    checks++; if (data_b0 !== 16'hFFFF) begin errors++; $display("[TB] FAIL low_blank got=%h exp=%h", data_b0, 16'hFFFF); end
    run_to(33);
    checks++; if (data_b0 !== 16'hFE80) begin errors++; $display("[TB] FAIL low_lit_8 got=%h exp=%h", data_b0, 16'hFE80); end
    run_to(168);
    checks++; if (data_b0 !== 16'hFBC0) begin errors++; $display("[TB] FAIL low_digit2 got=%h exp=%h", data_b0, 16'hFBC0); end
    reset_b = 1'b1;
    value_b0 = 32'h0000_0009;
    tick();
    checks++; if (data_b0 !== 16'hFFFF) begin errors++; $display("[TB] FAIL midslot_reset got=%h exp=%h", data_b0, 16'hFFFF); end
    checks++; if (digit_idx_b !== 3'd0) begin errors++; $display("[TB] FAIL midslot_reset_idx got=%0d exp=%0d", digit_idx_b, 0); end
    reset_b = 1'b0;
    cyc = 0;
    run_to(33);
    checks++; if (data_b0 !== 16'hFE90) begin errors++; $display("[TB] FAIL restart_digit0 got=%h exp=%h", data_b0, 16'hFE90); end
    checks++; if (digit_idx_b !== 3'd0) begin errors++; $display("[TB] FAIL restart_idx got=%0d exp=%0d", digit_idx_b, 0); end
  endtask

`ifdef SEG7_SCAN_DIM_EN
  task automatic test_dim();
    tick();
    reset_c = 1'b0;
    cyc = 0;
    run_to(33);
    checks++; if (data_c0 !== 16'h013F) begin errors++; $display("[TB] FAIL dim_lit_start got=%h exp=%h", data_c0, 16'h013F); end
    run_to(128);
    checks++; if (data_c0 !== 16'h013F) begin errors++; $display("[TB] FAIL dim_lit_end got=%h exp=%h", data_c0, 16'h013F); end
    run_to(129);
    checks++; if (data_c0 !== 16'h0000) begin errors++; $display("[TB] FAIL dim_dark got=%h exp=%h", data_c0, 16'h0000); end
    run_to(130);
    brightness_c = 4'hF;
    run_to(256);
    checks++; if (data_c0 !== 16'h0000) begin errors++; $display("[TB] FAIL dim_dark_end got=%h exp=%h", data_c0, 16'h0000); end
    run_to(386);
    checks++; if (data_c0 !== 16'h0000) begin errors++; $display("[TB] FAIL dim_no_early_update got=%h exp=%h", data_c0, 16'h0000); end
    run_to(2177);
    checks++; if (data_c0 !== 16'h013F) begin errors++; $display("[TB] FAIL dim_new_brightness got=%h exp=%h", data_c0, 16'h013F); end
  endtask
`endif

  initial begin
    test_reset();
    test_slot_timing();
    test_blank_dp();
    test_full_scan();
    test_snapshot();
    test_polarity();
`ifdef SEG7_SCAN_DIM_EN
    test_dim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
